// File: rtl/spi_master_arb_if.sv
// Requester/SPI bundle for spi_master_arb.
// master modport: the arbiter/SPI master side; slave modport: requesters and SPI observer.
interface spi_master_arb_if #(
    parameter int DATA_W = 4
) ();
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic              busy;
    logic              sclk;
    logic              ss;
    logic              mosi;

    modport master (
        input  req0, data0, req1, data1,
        output ack0, ack1, busy, sclk, ss, mosi
    );

    modport slave (
        output req0, data0, req1, data1,
        input  ack0, ack1, busy, sclk, ss, mosi
    );
endinterface

// File: rtl/spi_master_arb.sv
// Two-requester SPI master: arbitrates req0/req1, latches the winning word and
// shifts it MSB first (sclk idles high, mosi changes on sclk falling edge).
// Optional macro FIXED_PRIO_EN: requester 0 always wins; round-robin pointer removed.
module spi_master_arb #(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 5,
    parameter int GAP_CYC = 2
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_arb_if.master bus
);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] sh_next;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              grant1;

`ifdef FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is not asking.
    always_comb begin
        grant1 = bus.req1 & ~bus.req0;
    end
`else
    logic rr_q, rr_d;   // 0: favour requester 0, 1: favour requester 1

    // Round-robin pick; pointer only matters when both request.
    always_comb begin
        grant1 = bus.req1 & (~bus.req0 | rr_q);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`endif

    // State and registered outputs; reset aborts any frame with sclk/ss high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b1;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        sh_next = shreg_q << 1;
`ifndef FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    shreg_d = grant1 ? bus.data1 : bus.data0;
                    ack1_d  = grant1;
                    ack0_d  = ~grant1;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
`ifndef FIXED_PRIO_EN
                    rr_d    = ~grant1;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = shreg_q[DATA_W-1];
                    bit_d   = BIT_W'(1);
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q < BIT_LAST) begin
                        sclk_d  = 1'b0;
                        shreg_d = sh_next;
                        mosi_d  = sh_next[DATA_W-1];
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = S_LOW;
                    end else begin
                        ss_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sclk = sclk_q;
    assign bus.ss   = ss_q;
    assign bus.mosi = mosi_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: default instance (4-bit, CLK_DIV=5, GAP_CYC=2)
// driven from a vector table plus hand sequences, and an 8-bit CLK_DIV=1 instance.
module tb_spi_master_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_arb_if #(.DATA_W(4)) bus_a ();
    spi_master_arb_if #(.DATA_W(8)) bus_b ();

    spi_master_arb #(.DATA_W(4), .CLK_DIV(5), .GAP_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    spi_master_arb #(.DATA_W(8), .CLK_DIV(1), .GAP_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave-side monitor for instance A ----------------
    int fr_word_q[$], fr_edge_q[$], fr_len_q[$], fr_gap_q[$], busy_len_q[$];
    int sh = 0, nedge = 0, sslow = 0, sshigh = 0, blen = 0, lowrun = 0;
    int viol = 0, ack_viol = 0, sclk_rises = 0;
    logic p_sclk = 1'b1, p_ss = 1'b1, p_mosi = 1'b0, p_busy = 1'b0, p_ack = 1'b0;

    always @(negedge clk) begin
        if (p_sclk === 1'b0 && bus_a.sclk === 1'b1) sclk_rises++;
        if (bus_a.ss === 1'b0) begin
            if (p_ss !== 1'b0) begin
                fr_gap_q.push_back(sshigh);
                sh = 0; nedge = 0; sslow = 0; lowrun = 0;
            end
            sslow++;
            if (p_sclk === 1'b0 && bus_a.sclk === 1'b1) begin
                sh = (sh << 1) | int'(bus_a.mosi);
                nedge++;
                if (lowrun != 5) viol++;
                lowrun = 0;
            end
            if (bus_a.sclk === 1'b0) lowrun++;
            if (p_ss === 1'b0 && bus_a.mosi !== p_mosi && !(p_sclk === 1'b1 && bus_a.sclk === 1'b0))
                viol++;
        end else begin
            if (p_ss === 1'b0) begin
                fr_word_q.push_back(sh);
                fr_edge_q.push_back(nedge);
                fr_len_q.push_back(sslow);
                sshigh = 0;
            end
            sshigh++;
        end
        if (bus_a.busy === 1'b1) blen++;
        else if (p_busy === 1'b1) begin
            busy_len_q.push_back(blen);
            blen = 0;
        end
        if (bus_a.ack0 === 1'b1 && bus_a.ack1 === 1'b1) ack_viol++;
        if ((bus_a.ack0 === 1'b1 || bus_a.ack1 === 1'b1) && p_ack === 1'b1) ack_viol++;
        p_sclk = bus_a.sclk;
        p_ss   = bus_a.ss;
        p_mosi = bus_a.mosi;
        p_busy = bus_a.busy;
        p_ack  = bus_a.ack0 | bus_a.ack1;
    end

    task automatic flush_mon();
        fr_word_q.delete(); fr_edge_q.delete(); fr_len_q.delete();
        fr_gap_q.delete(); busy_len_q.delete();
        blen = 0;
    endtask

    task automatic wait_ack(input int budget, output int which);
        which = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.ack0 === 1'b1) begin which = 0; break; end
            if (bus_a.ack1 === 1'b1) begin which = 1; break; end
        end
    endtask

    // Waits for the next completed frame and checks word, edge count, ss/busy lengths.
    task automatic pop_frame(input string name, input int exp_word, input int exp_gap);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (fr_word_q.size() > 0) && (busy_len_q.size() > 0);
        end
        check({name, " done"}, 32'(ok), 32'd1);
        if (ok) begin
            check({name, " word"}, fr_word_q.pop_front(), exp_word);
            check({name, " sclk rises"}, fr_edge_q.pop_front(), 4);
            check({name, " ss low"}, fr_len_q.pop_front(), 45);
            check({name, " busy"}, busy_len_q.pop_front(), 47);
            if (exp_gap >= 0) check({name, " gap"}, fr_gap_q.pop_front(), exp_gap);
            else void'(fr_gap_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        flush_mon();
    endtask

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] d0;
        logic [3:0] d1;
        int         exp_ack;
        logic [3:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int which;
        int idle_viol;
        int snap;
        int acked, sslen, word, edges;
        logic pb_sclk;

        // Table filled assuming a fresh reset (pointer favours requester 0).
        vecs[0] = '{1'b1, 1'b0, 4'h1, 4'h0, 0, 4'h1};
`ifdef FIXED_PRIO_EN
        vecs[1] = '{1'b1, 1'b1, 4'hA, 4'h5, 0, 4'hA};
        vecs[2] = '{1'b1, 1'b1, 4'hA, 4'h5, 0, 4'hA};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 4'h9, 1, 4'h9};
        vecs[4] = '{1'b1, 1'b1, 4'h6, 4'hE, 0, 4'h6};
        vecs[5] = '{1'b1, 1'b1, 4'h3, 4'hC, 0, 4'h3};
`else
        vecs[1] = '{1'b1, 1'b1, 4'hA, 4'h5, 1, 4'h5};
        vecs[2] = '{1'b1, 1'b1, 4'hA, 4'h5, 0, 4'hA};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 4'h9, 1, 4'h9};
        vecs[4] = '{1'b1, 1'b1, 4'h6, 4'hE, 0, 4'h6};
        vecs[5] = '{1'b1, 1'b1, 4'h3, 4'hC, 1, 4'hC};
`endif

        // Reset with random inputs.
        rst_n = 1'b0;
        bus_a.req0 = 1'($urandom); bus_a.req1 = 1'($urandom);
        bus_a.data0 = 4'($urandom); bus_a.data1 = 4'($urandom);
        bus_b.req0 = 1'($urandom); bus_b.req1 = 1'($urandom);
        bus_b.data0 = 8'($urandom); bus_b.data1 = 8'($urandom);
        repeat (3) @(negedge clk);
        check("reset A outputs", {26'd0, bus_a.sclk, bus_a.ss, bus_a.mosi, bus_a.busy, bus_a.ack0, bus_a.ack1}, 32'b110000);
        check("reset B outputs", {26'd0, bus_b.sclk, bus_b.ss, bus_b.mosi, bus_b.busy, bus_b.ack0, bus_b.ack1}, 32'b110000);
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
        rst_n = 1'b1;
        idle_viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({bus_a.sclk, bus_a.ss, bus_a.mosi, bus_a.busy, bus_a.ack0, bus_a.ack1} !== 6'b110000) idle_viol++;
            if ({bus_b.sclk, bus_b.ss, bus_b.mosi, bus_b.busy, bus_b.ack0, bus_b.ack1} !== 6'b110000) idle_viol++;
        end
        check("idle after reset", idle_viol, 0);
        flush_mon();

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            bus_a.req0 = vecs[i].r0; bus_a.req1 = vecs[i].r1;
            bus_a.data0 = vecs[i].d0; bus_a.data1 = vecs[i].d1;
            wait_ack(20, which);
            check($sformatf("v%0d ack", i), which, vecs[i].exp_ack);
            bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
            bus_a.data0 = ~vecs[i].d0; bus_a.data1 = ~vecs[i].d1;
            pop_frame($sformatf("v%0d", i), int'(vecs[i].exp_word), -1);
        end

        // Request that drops before the sampling edge is not granted.
        @(negedge clk);
        #1 bus_a.req0 = 1'b1;
        #2 bus_a.req0 = 1'b0;
        wait_ack(20, which);
        check("glitch no grant", which, -1);
        check("glitch no frame", fr_word_q.size(), 0);

        // Contention from reset, both held until acked: 0xA then 0x5, then 0 again.
        do_reset();
        bus_a.req0 = 1'b1; bus_a.req1 = 1'b1;
        bus_a.data0 = 4'hA; bus_a.data1 = 4'h5;
        wait_ack(20, which);
        check("cont first ack", which, 0);
        bus_a.req0 = 1'b0; bus_a.data0 = 4'hF;
        wait_ack(150, which);
        check("cont second ack", which, 1);
        bus_a.req1 = 1'b0; bus_a.data1 = 4'h0;
        pop_frame("cont f1", 4'hA, -1);
        pop_frame("cont f2", 4'h5, 3);
        bus_a.req0 = 1'b1; bus_a.req1 = 1'b1;
        bus_a.data0 = 4'h2; bus_a.data1 = 4'h7;
        wait_ack(20, which);
        check("cont third ack", which, 0);
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        pop_frame("cont f3", 4'h2, -1);

        // Back-to-back from requester 1 with data changed after each ack.
        bus_a.req1 = 1'b1; bus_a.data1 = 4'h3;
        wait_ack(20, which);
        check("b2b ack1", which, 1);
        bus_a.data1 = 4'hC;
        wait_ack(150, which);
        check("b2b ack2", which, 1);
        bus_a.req1 = 1'b0; bus_a.data1 = 4'h0;
        pop_frame("b2b f1", 4'h3, -1);
        pop_frame("b2b f2", 4'hC, 3);

        // Abort during the third bit's LOW phase.
        bus_a.req0 = 1'b1; bus_a.data0 = 4'h6;
        wait_ack(20, which);
        check("abort ack", which, 0);
        bus_a.req0 = 1'b0;
        repeat (27) @(negedge clk);
        check("abort in LOW", {31'd0, bus_a.sclk}, 0);
        rst_n = 1'b0;
        #1;
        check("abort ss/sclk", {30'd0, bus_a.ss, bus_a.sclk}, 32'b11);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap = sclk_rises;
        idle_viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.ss !== 1'b1 || bus_a.busy !== 1'b0) idle_viol++;
        end
        check("abort quiet", idle_viol, 0);
        check("abort no sclk", sclk_rises - snap, 0);
        flush_mon();
        bus_a.req0 = 1'b1; bus_a.data0 = 4'h9;
        wait_ack(20, which);
        check("post-abort ack", which, 0);
        bus_a.req0 = 1'b0;
        pop_frame("post-abort", 4'h9, -1);

        // Instance B: CLK_DIV=1, DATA_W=8.
        bus_b.req0 = 1'b1; bus_b.data0 = 8'hC3;
        acked = 0; sslen = 0; word = 0; edges = 0; pb_sclk = bus_b.sclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_b.ack0 === 1'b1) begin acked++; bus_b.req0 = 1'b0; end
            if (bus_b.ss === 1'b0) sslen++;
            if (pb_sclk === 1'b0 && bus_b.sclk === 1'b1) begin
                word = (word << 1) | int'(bus_b.mosi);
                edges++;
            end
            pb_sclk = bus_b.sclk;
            if (sslen > 0 && bus_b.ss === 1'b1) break;
        end
        check("B acks", acked, 1);
        check("B ss low", sslen, 17);
        check("B word", word, 8'hC3);
        check("B sclk rises", edges, 8);

        check("ack pulse shape", ack_viol, 0);
        check("mosi/sclk timing", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
